// File: rtl/bus_rr_scheduler.sv
// Round-robin bus transfer controller: grants one pending device, pops its
// head packet, decodes the destination byte and pushes it to the target(s).
module bus_rr_scheduler #(
    parameter int          DRVRS     = 8,
    parameter int          PCKG_SZ   = 16,
    parameter logic [7:0]  BROADCAST = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DRVRS-1:0]         pndng,
    input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
    output logic [DRVRS-1:0]         pop,
    output logic [DRVRS-1:0]         push,
    output logic [PCKG_SZ-1:0]       D_push,
    output logic                     busy,
    output logic [7:0]               grant_id,
    output logic [15:0]              pkt_cnt,
    output logic [7:0]               drop_cnt
);

    typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

    localparam logic [7:0] LAST = 8'(DRVRS - 1);

    state_t               state_q, state_d;
    logic [7:0]           win_q, win_d;
    logic [7:0]           grant_q, grant_d;
    logic [DRVRS-1:0]     pop_q, pop_d;
    logic [DRVRS-1:0]     push_q, push_d;
    logic [PCKG_SZ-1:0]   dpush_q, dpush_d;
    logic [15:0]          pkt_q, pkt_d;
    logic [7:0]           drop_q, drop_d;

    logic                 found;
    logic [7:0]           win_sel;
    logic [PCKG_SZ-1:0]   pkt;
    logic [7:0]           dest;
    logic [DRVRS-1:0]     src_oh, dst_oh, route;

    // Two passes: first pending device above the pointer, else lowest pending.
    always_comb begin
        found   = 1'b0;
        win_sel = 8'd0;
        for (int i = 0; i < DRVRS; i++) begin
            if (!found && pndng[i] && grant_q != LAST && 8'(i) > grant_q) begin
                found   = 1'b1;
                win_sel = 8'(i);
            end
        end
        for (int i = 0; i < DRVRS; i++) begin
            if (!found && pndng[i]) begin
                found   = 1'b1;
                win_sel = 8'(i);
            end
        end
    end

    always_comb begin
        pkt    = '0;
        src_oh = '0;
        dst_oh = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (win_q == 8'(i)) pkt = D_pop[i*PCKG_SZ +: PCKG_SZ];
        end
        dest = pkt[PCKG_SZ-1 -: 8];
        for (int i = 0; i < DRVRS; i++) begin
            src_oh[i] = (win_q == 8'(i));
            dst_oh[i] = (dest == 8'(i));
        end
        if (dest == BROADCAST)
            route = ~src_oh;
        else if (int'(dest) < DRVRS && dest != win_q)
            route = dst_oh;
        else
            route = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= LAST;
            grant_q <= LAST;
            pop_q   <= '0;
            push_q  <= '0;
            dpush_q <= '0;
            pkt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            dpush_q <= dpush_d;
            pkt_q   <= pkt_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|pndng) state_d = POP;
            POP:     state_d = PUSH;
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_d   = win_q;
        grant_d = grant_q;
        pop_d   = '0;
        push_d  = '0;
        dpush_d = dpush_q;
        pkt_d   = pkt_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    win_d = win_sel;
                    for (int i = 0; i < DRVRS; i++)
                        pop_d[i] = (win_sel == 8'(i));
                end
            end
            POP: begin
                grant_d = win_q;
                push_d  = route;
                dpush_d = pkt;
                if (|route)
                    pkt_d = pkt_q + 16'd1;
                else if (drop_q != 8'hFF)
                    drop_d = drop_q + 8'd1;
            end
            default: ;
        endcase
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = dpush_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;
    assign pkt_cnt  = pkt_q;
    assign drop_cnt = drop_q;

endmodule
